// File: rtl/pulse_stretcher_pkg.sv
// Shared constants for the pulse stretcher: state encoding and counter sizing helpers.
package pulse_stretcher_pkg;

    typedef logic [1:0] ps_state_t;

    localparam ps_state_t S_IDLE    = 2'd0;
    localparam ps_state_t S_ACTIVE  = 2'd1;
    localparam ps_state_t S_HOLDOFF = 2'd2;

    localparam int HOLDOFF_W_MIN = 1;

    // Bits needed to hold a holdoff count of 0..holdoff, never less than one bit.
    function automatic int holdoff_w(input int holdoff);
        int w;
        w = $clog2(holdoff + 1);
        return (w < HOLDOFF_W_MIN) ? HOLDOFF_W_MIN : w;
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle trigger into a high pulse of programmable width, with
// optional retrigger and post-pulse holdoff selected at build time.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int HOLDOFF   = 0,
    parameter int RETRIGGER = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic [CNT_W-1:0] length,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             missed
);

    localparam int HOLDOFF_W = holdoff_w(HOLDOFF);
    // One down-counter serves both the pulse and the holdoff, so it spans both.
    localparam int CW        = max_w(CNT_W, HOLDOFF_W);

    localparam bit             HAS_HOLDOFF = (HOLDOFF > 0);
    localparam bit             USE_RETRIG  = (RETRIGGER != 0);
    localparam logic [CW-1:0]  CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE     = CW'(1'b1);
    localparam logic [CNT_W-1:0] LEN_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] LEN_ONE   = CNT_W'(1'b1);
    localparam logic [CW-1:0]  HOLD_LOAD   = HAS_HOLDOFF ? CW'(HOLDOFF - 1) : {CW{1'b0}};
    localparam ps_state_t      END_STATE   = HAS_HOLDOFF ? S_HOLDOFF : S_IDLE;

    ps_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_pulse;
    logic            r_busy;
    logic            r_done;
    logic            r_missed;

    ps_state_t       w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_len_load;
    logic            w_done_nxt;
    logic            w_missed_nxt;

    // Next-state, counter and strobe decode for the three-state sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = 1'b0;
        w_missed_nxt = 1'b0;

        // A zero length is stretched to one cycle, hence max(length,1)-1.
        if (length == LEN_ZERO) begin
            w_len_load = CNT_ZERO;
        end else begin
            w_len_load = CW'(length - LEN_ONE);
        end

        case (r_state)
            S_IDLE: begin
                if (trigger) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = w_len_load;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            S_ACTIVE: begin
                w_missed_nxt = trigger && !USE_RETRIG;
                if (trigger && USE_RETRIG) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = w_len_load;
                end else if (r_cnt != CNT_ZERO) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end else begin
                    w_state_nxt = END_STATE;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_done_nxt  = 1'b1;
                end
            end
            S_HOLDOFF: begin
                w_missed_nxt = trigger;
                if (r_cnt != CNT_ZERO) begin
                    w_state_nxt = S_HOLDOFF;
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs; reset wins over any same-cycle trigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= CNT_ZERO;
            r_pulse  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pulse  <= (w_state_nxt == S_ACTIVE);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= w_done_nxt;
            r_missed <= w_missed_nxt;
        end
    end

    assign pulse_out = r_pulse;
    assign busy      = r_busy;
    assign done      = r_done;
    assign missed    = r_missed;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: three build variants driven by cycle-indexed
// vectors with hand-computed expected outputs.
module tb_pulse_stretcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig_a, trig_b, trig_c;
    logic [15:0] length;
    logic        pulse_a, busy_a, done_a, missed_a;
    logic        pulse_b, busy_b, done_b, missed_b;
    logic        pulse_c, busy_c, done_c, missed_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // A: no retrigger, no holdoff.  B: retrigger.  C: holdoff of 3 cycles.
    pulse_stretcher #(.CNT_W(16), .HOLDOFF(0), .RETRIGGER(0)) u_dut_a (
        .clk(clk), .reset(reset), .trigger(trig_a), .length(length),
        .pulse_out(pulse_a), .busy(busy_a), .done(done_a), .missed(missed_a));

    pulse_stretcher #(.CNT_W(16), .HOLDOFF(0), .RETRIGGER(1)) u_dut_b (
        .clk(clk), .reset(reset), .trigger(trig_b), .length(length),
        .pulse_out(pulse_b), .busy(busy_b), .done(done_b), .missed(missed_b));

    pulse_stretcher #(.CNT_W(16), .HOLDOFF(3), .RETRIGGER(0)) u_dut_c (
        .clk(clk), .reset(reset), .trigger(trig_c), .length(length),
        .pulse_out(pulse_c), .busy(busy_c), .done(done_c), .missed(missed_c));

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit t of each vector describes cycle t; trigger at cycle t is seen by the DUT at the end of cycle t.
    task automatic run(input string tag, input int dut, input int ncyc,
                       input logic [15:0] trig_v, input logic [15:0] len0, input logic [15:0] len1,
                       input logic [15:0] e_pulse, input logic [15:0] e_busy,
                       input logic [15:0] e_done, input logic [15:0] e_missed);
        int ntrig;
        logic [3:0] o;
        ntrig = 0;
        for (int t = 0; t < ncyc; t++) begin
            case (dut)
                0:       o = {missed_a, done_a, busy_a, pulse_a};
                1:       o = {missed_b, done_b, busy_b, pulse_b};
                default: o = {missed_c, done_c, busy_c, pulse_c};
            endcase
            check($sformatf("%s pulse t%0d", tag, t),  o[0], e_pulse[t]);
            check($sformatf("%s busy t%0d", tag, t),   o[1], e_busy[t]);
            check($sformatf("%s done t%0d", tag, t),   o[2], e_done[t]);
            check($sformatf("%s missed t%0d", tag, t), o[3], e_missed[t]);
            trig_a = (dut == 0) && trig_v[t];
            trig_b = (dut == 1) && trig_v[t];
            trig_c = (dut == 2) && trig_v[t];
            if (trig_v[t]) begin
                length = (ntrig == 0) ? len0 : len1;
                ntrig++;
            end
            tick();
        end
        trig_a = 1'b0;
        trig_b = 1'b0;
        trig_c = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        reset  = 1'b1;
        trig_a = 1'b0;
        trig_b = 1'b0;
        trig_c = 1'b0;
        length = 16'd0;
        tick();
        tick();
        reset = 1'b0;
        check("rst pulse_a", pulse_a, 1'b0);  check("rst busy_a", busy_a, 1'b0);
        check("rst done_a", done_a, 1'b0);    check("rst missed_a", missed_a, 1'b0);
        check("rst pulse_b", pulse_b, 1'b0);  check("rst busy_b", busy_b, 1'b0);
        check("rst pulse_c", pulse_c, 1'b0);  check("rst busy_c", busy_c, 1'b0);
        repeat (9) tick();

        run("basic", 0, 8, 16'b0000_0000_0000_0001, 16'd5, 16'd5,
            16'b0000_0000_0011_1110, 16'b0000_0000_0011_1110,
            16'b0000_0000_0100_0000, 16'b0000_0000_0000_0000);

        run("zero_len", 0, 4, 16'b0000_0000_0000_0001, 16'd0, 16'd0,
            16'b0000_0000_0000_0010, 16'b0000_0000_0000_0010,
            16'b0000_0000_0000_0100, 16'b0000_0000_0000_0000);

        run("retrig", 1, 9, 16'b0000_0000_0000_0101, 16'd4, 16'd4,
            16'b0000_0000_0111_1110, 16'b0000_0000_0111_1110,
            16'b0000_0000_1000_0000, 16'b0000_0000_0000_0000);

        run("no_retrig", 0, 7, 16'b0000_0000_0000_0101, 16'd4, 16'd4,
            16'b0000_0000_0001_1110, 16'b0000_0000_0001_1110,
            16'b0000_0000_0010_0000, 16'b0000_0000_0000_1000);

        run("holdoff", 2, 12, 16'b0000_0000_1001_0001, 16'd2, 16'd2,
            16'b0000_0011_0000_0110, 16'b0000_1111_0011_1110,
            16'b0000_0100_0000_1000, 16'b0000_0000_0010_0000);

        run("retrig_last", 1, 8, 16'b0000_0000_0000_1001, 16'd3, 16'd2,
            16'b0000_0000_0011_1110, 16'b0000_0000_0011_1110,
            16'b0000_0000_0100_0000, 16'b0000_0000_0000_0000);

        run("back2back", 0, 8, 16'b0000_0000_0000_1001, 16'd2, 16'd2,
            16'b0000_0000_0011_0110, 16'b0000_0000_0011_0110,
            16'b0000_0000_0100_1000, 16'b0000_0000_0000_0000);

        run("done_missed", 0, 5, 16'b0000_0000_0000_0101, 16'd2, 16'd2,
            16'b0000_0000_0000_0110, 16'b0000_0000_0000_0110,
            16'b0000_0000_0000_1000, 16'b0000_0000_0000_1000);

        // Reset in the middle of a long pulse, with a trigger on the reset cycle.
        length = 16'd100;
        trig_a = 1'b1;
        tick();
        trig_a = 1'b0;
        repeat (19) tick();
        check("midrst pulse before", pulse_a, 1'b1);
        reset  = 1'b1;
        trig_a = 1'b1;
        length = 16'd5;
        tick();
        reset  = 1'b0;
        trig_a = 1'b0;
        check("midrst pulse", pulse_a, 1'b0);
        check("midrst busy", busy_a, 1'b0);
        check("midrst done", done_a, 1'b0);
        check("midrst missed", missed_a, 1'b0);
        tick();
        check("midrst discard pulse", pulse_a, 1'b0);
        check("midrst no done", done_a, 1'b0);
        length = 16'd3;
        trig_a = 1'b1;
        tick();
        trig_a = 1'b0;
        for (int t = 0; t < 4; t++) begin
            check($sformatf("after rst pulse t%0d", t), pulse_a, (t < 3) ? 1'b1 : 1'b0);
            check($sformatf("after rst done t%0d", t), done_a, (t == 3) ? 1'b1 : 1'b0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts a single-cycle pulse, typically the output of an edge detector, back into a level: a high pulse of programmable width.
- Drives LEDs, strobes and enables on the DE2-115 demos, where one-cycle events are too short to observe or to cross into slower logic.
- Retrigger policy and a post-pulse holdoff are set at build time.

Parameters:
- CNT_W, 16: width of the length counter and of the length input.
- HOLDOFF, 0: number of low cycles forced after each pulse; 0 disables the holdoff.
- RETRIGGER, 0: 1 = a trigger while the pulse is active reloads the counter; 0 = the trigger is ignored and flagged as missed.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- trigger  input  1  single-cycle request pulse; a level held high is seen as a trigger on every cycle.
- length  input  CNT_W  pulse width in cycles, sampled on the accepting trigger cycle; 0 is treated as 1.
- pulse_out  output  1  stretched pulse, registered.
- busy  output  1  high in ACTIVE or HOLDOFF, registered.
- done  output  1  one-cycle strobe on the first cycle after pulse_out falls, registered.
- missed  output  1  one-cycle strobe, one cycle after a trigger that was rejected, registered.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset: state=IDLE, counter=0, and pulse_out, busy, done, missed all 0.
  - Reset mid-pulse drops pulse_out on the next edge with no done strobe.
- States: IDLE, ACTIVE, HOLDOFF.
- IDLE:
  - trigger=1 moves to ACTIVE.
  - The counter loads max(length,1)-1.
  - pulse_out=1 and busy=1 from the next cycle, so latency from trigger to pulse_out is 1 cycle.
- ACTIVE:
  - pulse_out=1 while the counter is nonzero; the counter decrements by 1 each cycle.
  - Counter==0 with no reload ends the pulse:
    - pulse_out goes 0 next cycle and done goes 1 for one cycle.
    - Next state is HOLDOFF with counter=HOLDOFF-1 if HOLDOFF>0, else IDLE.
  - Exact width: pulse_out is high for exactly max(length,1) consecutive cycles.
- Trigger during ACTIVE with RETRIGGER=1:
  - The counter reloads with max(new length,1)-1 and pulse_out stays high without a gap.
  - Total width = cycles already elapsed + new length.
  - A trigger on the final cycle (counter==0) also reloads; no done strobe is produced.
- Trigger during ACTIVE with RETRIGGER=0: the trigger is ignored and missed=1 for one cycle.
- HOLDOFF:
  - pulse_out=0 and busy=1; the counter decrements.
  - Counter==0 returns to IDLE; busy goes 0 the next cycle.
  - Any trigger in HOLDOFF produces missed=1 and is not queued.
- Back-to-back operation:
  - With HOLDOFF=0, a trigger on the cycle done is asserted is accepted from IDLE.
  - Minimum low gap between pulses is therefore 1 cycle.
- Simultaneous events:
  - done and missed may assert together; they are independent.
  - A trigger on the reset cycle is discarded.
- Width rule: length is unsigned CNT_W bits, so the maximum pulse is 2^CNT_W-1 cycles. The counter never wraps.
- No combinational path from any input to any output.

Decomposition:
- Package pulse_stretcher_pkg holds the state encoding constants (IDLE=2'd0, ACTIVE=2'd1, HOLDOFF=2'd2) and a HOLDOFF_W helper constant.
  - HOLDOFF_W = clog2(HOLDOFF+1), minimum 1.
- Single module, no sub-module.
- A separate counter sub-module is not warranted: one down-counter is shared between ACTIVE and HOLDOFF, sized max(CNT_W, HOLDOFF_W).

Test Plan:
- Basic width: reset, then trigger pulse with length=5 at cycle 10 -> pulse_out high cycles 11..15, done=1 at cycle 16, busy low at cycle 16.
- Zero length: length=0 trigger -> pulse_out high exactly 1 cycle, done the following cycle.
- Retrigger, RETRIGGER=1: length=4 at t=0, second trigger length=4 at t=2 -> pulse_out high t=1..6 continuously (6 cycles), one done at t=7, missed never 1.
- No retrigger, RETRIGGER=0: same stimulus -> pulse_out high t=1..4, missed=1 at t=3, done at t=5.
- Holdoff, HOLDOFF=3: length=2 trigger at t=0, triggers at t=4 and t=7 -> pulse t=1..2, done t=3, missed t=5, busy low from t=6, t=7 trigger accepted with pulse from t=8.
- Reset mid-pulse: length=100, assert reset at cycle 20 for 1 cycle -> all outputs 0 at cycle 21, no done, idle trigger accepted afterwards.
